adc_capture_ctrl: RTL and testbench

Sequencer for the trigger-based ADC capture datapath. It clears the trigger/max-sum logic, arms capture, and forwards triggered sample beats from the ADC stream to the DMA-facing AXI-Stream with per-event length and event-count limits. It re-arms the trigger between events and reports progress, drops and completion to the register bank. It sits between the ADC trigger block and the stream writer.

---
 rtl/adc_capture_ctrl.sv | 108 ++++++++++
 tb/tb_adc_capture_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: arms the ADC trigger and forwards triggered beats with per-event length and event-count limits
module adc_capture_ctrl #(
   parameter int DATA_WIDTH   = 129,
   parameter int CLEAR_CYCLES = 4
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  arm,
   input  logic                  disarm,
   input  logic [31:0]           samples_per_event,
   input  logic [15:0]           max_events,
   input  logic [15:0]           holdoff,
   input  logic                  s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  reset_trigger,
   output logic                  reset_max_sum,
   output logic [2:0]            state,
   output logic [15:0]           events_done,
   output logic [15:0]           drop_count,
   output logic                  done
);
   localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_ARMED = 3'd2,
                          S_CAPTURE = 3'd3, S_HOLDOFF = 3'd4, S_DONE = 3'd5;

   logic [2:0]  nxt;
   logic [31:0] tmr, bcnt, spe, ho;
   logic        beat, last, ev_end, run_full, rt_d, rms_d, done_d;

   assign spe = samples_per_event == 32'd0 ? 32'd1 : samples_per_event;
   assign ho = holdoff == 16'd0 ? 32'd1 : {16'd0, holdoff};
   assign beat = !disarm && s_axis_tvalid && (state == S_ARMED || state == S_CAPTURE);
   assign last = bcnt + 32'd1 == spe;
   assign ev_end = (beat && last) || (!disarm && !s_axis_tvalid && state == S_CAPTURE);
   assign run_full = max_events != 16'd0 && events_done == max_events;

   // state, phase timer and control levels; the timer restarts on every state change
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= S_IDLE;
         tmr           <= '0;
         reset_trigger <= 1'b1;
         reset_max_sum <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= nxt;
         tmr           <= nxt != state ? '0 : tmr + 32'd1;
         reset_trigger <= rt_d;
         reset_max_sum <= rms_d;
         done          <= done_d;
      end
   end

   // sequencing; disarm overrides everything including a simultaneous arm
   always_comb begin
      nxt = state;
      if (disarm) nxt = S_IDLE;
      else begin
         case (state)
            S_IDLE, S_DONE: if (arm) nxt = S_CLEAR;
            S_CLEAR:        if (tmr == 32'(CLEAR_CYCLES - 1)) nxt = S_ARMED;
            S_ARMED:        if (s_axis_tvalid) nxt = last ? S_HOLDOFF : S_CAPTURE;
            S_CAPTURE:      if (ev_end) nxt = S_HOLDOFF;
            S_HOLDOFF:      if (tmr == ho - 32'd1) nxt = run_full ? S_DONE : S_ARMED;
            default:        nxt = S_IDLE;
         endcase
      end
   end

   // control levels for the state being entered, so they register together with it
   always_comb begin
      rt_d   = !(nxt == S_ARMED || nxt == S_CAPTURE);
      rms_d  = nxt == S_CLEAR;
      done_d = nxt == S_DONE;
   end

   // output slice, beat counter and run statistics
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         bcnt          <= '0;
         events_done   <= '0;
         drop_count    <= '0;
      end else begin
         if (beat && (!m_axis_tvalid || m_axis_tready)) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= last;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
         bcnt <= beat ? bcnt + 32'd1 : (state == S_CAPTURE ? bcnt : '0);
         if (nxt == S_CLEAR && state != S_CLEAR) begin
            events_done <= '0;
            drop_count  <= '0;
         end else begin
            if (ev_end) events_done <= events_done + 16'd1;
            if (beat && m_axis_tvalid && !m_axis_tready && drop_count != 16'hFFFF)
               drop_count <= drop_count + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed scenarios plus random traffic checked cycle by cycle against a behavioural model
module tb_adc_capture_ctrl;
   localparam int DW  = 129;
   localparam int CLR = 4;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          arm = 1'b0;
   logic          disarm = 1'b0;
   logic [31:0]   samples_per_event = 32'd1;
   logic [15:0]   max_events = 16'd0;
   logic [15:0]   holdoff = 16'd0;
   logic          s_axis_tvalid = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          m_axis_tready = 1'b1;
   logic          m_axis_tvalid, m_axis_tlast, reset_trigger, reset_max_sum, done;
   logic [DW-1:0] m_axis_tdata;
   logic [2:0]    state;
   logic [15:0]   events_done, drop_count;

   int total = 0;
   int bad = 0;

   adc_capture_ctrl #(.DATA_WIDTH(DW), .CLEAR_CYCLES(CLR)) dut (
      .aclk(aclk), .aresetn(aresetn), .arm(arm), .disarm(disarm),
      .samples_per_event(samples_per_event), .max_events(max_events), .holdoff(holdoff),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .m_axis_tready(m_axis_tready), .reset_trigger(reset_trigger), .reset_max_sum(reset_max_sum),
      .state(state), .events_done(events_done), .drop_count(drop_count), .done(done)
   );

   always #5 aclk = ~aclk;

   // behavioural model: phase number, countdown of cycles left in a timed phase, beats taken this event
   int            ph = 0;
   int            left = 0;
   longint        cnt = 0;
   logic          e_v = 1'b0;
   logic          e_l = 1'b0;
   logic [DW-1:0] e_d = '0;
   logic [15:0]   e_ev = 16'd0;
   logic [15:0]   e_dc = 16'd0;

   task automatic model_reset();
      ph = 0;
      left = 0;
      cnt = 0;
      e_v = 1'b0;
      e_l = 1'b0;
      e_d = '0;
      e_ev = 16'd0;
      e_dc = 16'd0;
   endtask

   task automatic model_step();
      longint want;
      int gap;
      bit fwd, lst, fin;
      want = samples_per_event == 32'd0 ? 64'd1 : longint'(samples_per_event);
      gap = holdoff == 16'd0 ? 1 : int'(holdoff);
      fwd = !disarm && s_axis_tvalid && (ph == 2 || ph == 3);
      lst = fwd && (cnt + 1 == want);
      fin = lst || (!disarm && ph == 3 && !s_axis_tvalid);
      if (fwd && (!e_v || m_axis_tready)) begin
         e_v = 1'b1;
         e_d = s_axis_tdata;
         e_l = lst;
      end else begin
         if (fwd && e_dc != 16'hFFFF) e_dc++;
         if (m_axis_tready) e_v = 1'b0;
      end
      if (fwd) cnt++;
      if (fin) e_ev++;
      if (disarm) ph = 0;
      else if ((ph == 0 || ph == 5) && arm) begin
         ph = 1;
         left = CLR;
         e_ev = 16'd0;
         e_dc = 16'd0;
      end else if (ph == 1) begin
         left--;
         if (left == 0) begin
            ph = 2;
            cnt = 0;
         end
      end else if (fin) begin
         ph = 4;
         left = gap;
      end else if (ph == 2 && fwd) ph = 3;
      else if (ph == 4) begin
         left--;
         if (left == 0) begin
            ph = (max_events != 16'd0 && e_ev == max_events) ? 5 : 2;
            cnt = 0;
         end
      end
   endtask

   always @(posedge aclk or negedge aresetn)
      if (!aresetn) model_reset();
      else model_step();

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // observation statistics used by the directed scenarios
   int beats = 0, lasts = 0, rms_hi = 0, rt_run = 0, min_gap = 1000;
   bit seen_low = 1'b0, seen_hold = 1'b0;

   task automatic check_all();
      chk("state", state, ph);
      chk("reset_trigger", reset_trigger, !(ph == 2 || ph == 3));
      chk("reset_max_sum", reset_max_sum, ph == 1);
      chk("done", done, ph == 5);
      chk("tvalid", m_axis_tvalid, e_v);
      if (e_v) begin
         chk("tdata", m_axis_tdata, e_d);
         chk("tlast", m_axis_tlast, e_l);
      end
      chk("events_done", events_done, e_ev);
      chk("drop_count", drop_count, e_dc);
      if (reset_max_sum) rms_hi++;
      if (state == 3'd4) seen_hold = 1'b1;
      if (reset_trigger) rt_run++;
      else begin
         if (rt_run > 0 && seen_low && rt_run < min_gap) min_gap = rt_run;
         rt_run = 0;
         seen_low = 1'b1;
      end
   endtask

   // called at a falling edge with inputs already driven
   task automatic step();
      #1;
      if (m_axis_tvalid && m_axis_tready) begin
         beats++;
         if (m_axis_tlast) lasts++;
      end
      @(posedge aclk);
      @(negedge aclk);
      check_all();
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, output int n);
      n = 0;
      while (state != s && n < budget) begin
         step();
         n++;
      end
      chk("wait_state", state, s);
   endtask

   task automatic arm_run();
      int n;
      rms_hi = 0;
      arm = 1'b1;
      step();
      arm = 1'b0;
      wait_state(3'd2, 20, n);
      chk("arm_latency", n, CLR);
      chk("clear_len", rms_hi, CLR);
   endtask

   task automatic cfg(input int s, input int m, input int h);
      samples_per_event = 32'(s);
      max_events = 16'(m);
      holdoff = 16'(h);
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return r[DW-1:0];
   endfunction

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_state"}, state, 3'd0);
      chk({pfx, "_rt"}, reset_trigger, 1'b1);
      chk({pfx, "_rms"}, reset_max_sum, 1'b0);
      chk({pfx, "_tvalid"}, m_axis_tvalid, 1'b0);
      chk({pfx, "_tdata"}, m_axis_tdata, '0);
      chk({pfx, "_tlast"}, m_axis_tlast, 1'b0);
      chk({pfx, "_events"}, events_done, 16'd0);
      chk({pfx, "_drops"}, drop_count, 16'd0);
      chk({pfx, "_done"}, done, 1'b0);
   endtask

   initial begin
      logic [DW-1:0] d0;
      @(negedge aclk);
      chk_reset_vals("rst");
      @(negedge aclk);
      aresetn = 1'b1;
      step();

      // single event, continuous trigger burst longer than the event
      cfg(8, 1, 2);
      arm_run();
      beats = 0;
      lasts = 0;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         s_axis_tdata = rnd_data();
         step();
      end
      s_axis_tvalid = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("ev1_beats", beats, 8);
      chk("ev1_lasts", lasts, 1);
      chk("ev1_events", events_done, 16'd1);
      chk("ev1_done", done, 1'b1);
      chk("ev1_drops", drop_count, 16'd0);

      // three events with re-arm gap
      cfg(4, 3, 5);
      arm_run();
      beats = 0;
      lasts = 0;
      rt_run = 0;
      seen_low = 1'b0;
      min_gap = 1000;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         s_axis_tdata = rnd_data();
         step();
      end
      s_axis_tvalid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("multi_beats", beats, 12);
      chk("multi_lasts", lasts, 3);
      chk("multi_events", events_done, 16'd3);
      chk("multi_state", state, 3'd5);
      chk("multi_gap", min_gap, 5);

      // backpressure for six cycles starting at the first beat of a 10-beat event
      cfg(10, 1, 1);
      arm_run();
      beats = 0;
      lasts = 0;
      s_axis_tvalid = 1'b1;
      m_axis_tready = 1'b0;
      d0 = rnd_data();
      s_axis_tdata = d0;
      step();
      for (int i = 0; i < 5; i++) begin
         s_axis_tdata = rnd_data();
         step();
         chk("stall_hold", m_axis_tdata, d0);
      end
      m_axis_tready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         s_axis_tdata = rnd_data();
         step();
      end
      s_axis_tvalid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("bp_drops", drop_count, 16'd5);
      chk("bp_beats", beats, 5);
      chk("bp_lasts", lasts, 1);
      chk("bp_events", events_done, 16'd1);

      // trigger falls before the event length is reached
      cfg(100, 0, 3);
      arm_run();
      beats = 0;
      lasts = 0;
      seen_hold = 1'b0;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         s_axis_tdata = rnd_data();
         step();
      end
      s_axis_tvalid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("early_beats", beats, 7);
      chk("early_lasts", lasts, 0);
      chk("early_events", events_done, 16'd1);
      chk("early_hold", seen_hold, 1'b1);
      disarm = 1'b1;
      step();
      disarm = 1'b0;

      // abort mid-capture, then simultaneous arm and disarm
      cfg(50, 0, 2);
      arm_run();
      beats = 0;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_axis_tdata = rnd_data();
         step();
      end
      disarm = 1'b1;
      step();
      disarm = 1'b0;
      chk("abort_idle", state, 3'd0);
      for (int i = 0; i < 5; i++) begin
         s_axis_tdata = rnd_data();
         step();
      end
      s_axis_tvalid = 1'b0;
      chk("abort_beats", beats, 4);
      arm = 1'b1;
      disarm = 1'b1;
      step();
      arm = 1'b0;
      disarm = 1'b0;
      chk("both_idle", state, 3'd0);
      for (int i = 0; i < 3; i++) step();
      chk("both_still_idle", state, 3'd0);
      chk("both_beats", beats, 4);

      // asynchronous reset in the middle of a capture
      cfg(50, 0, 2);
      arm_run();
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_axis_tdata = rnd_data();
         step();
      end
      chk("pre_rst_capture", state, 3'd3);
      #2 aresetn = 1'b0;
      #1 chk_reset_vals("arst");
      s_axis_tvalid = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      step();
      arm_run();
      disarm = 1'b1;
      step();
      disarm = 1'b0;

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         disarm = $urandom_range(0, 149) == 0;
         arm = (ph == 0 || ph == 5) && $urandom_range(0, 5) == 0;
         if ((ph == 0 || ph == 5) && !arm)
            cfg($urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 4));
         if ($urandom_range(0, 3) == 0) s_axis_tvalid = !s_axis_tvalid;
         s_axis_tdata = rnd_data();
         m_axis_tready = $urandom_range(0, 3) != 0;
         step();
      end
      arm = 1'b0;
      disarm = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
